// File: rtl/adc_vscale_pkg.sv
// rtl/adc_vscale_pkg.sv - shared gain-code type, defaults and gain-to-shift mapping
package adc_vscale_pkg;

  typedef logic [2:0] sel_t;

  localparam int   PKG_DEF_SEL   = 3;
  localparam int   PKG_MAX_SHIFT = 10;
  localparam sel_t SEL_ILLEGAL   = 3'd7;

  // Code 7 has no gain of its own and falls back to the default code.
  function automatic int sel_to_shift(input sel_t sel, input int def_sel, input int max_shift);
    sel_t eff;
    eff = (sel == SEL_ILLEGAL) ? sel_t'(def_sel) : sel;
    return max_shift - int'(eff);
  endfunction

endpackage

// File: rtl/adc_vscale_sat.sv
// rtl/adc_vscale_sat.sv - stage-2 arithmetic: centre offset, clamp to row range, clip flag
module adc_vscale_sat #(
  parameter int ADC_W    = 14,
  parameter int PIX_W    = 8,
  parameter int Y_CENTER = 60,
  parameter int Y_MAX    = 2**PIX_W - 1
) (
  input  logic signed [ADC_W:0]   val_i,
  output logic        [PIX_W-1:0] y_o,
  output logic                    clip_o
);

  localparam int SW = PIX_W + ADC_W + 2;

  logic signed [SW-1:0] y_wide;

  assign y_wide = SW'(Y_CENTER) + {{(SW-ADC_W-1){val_i[ADC_W]}}, val_i};

  always_comb begin
    y_o    = y_wide[PIX_W-1:0];
    clip_o = 1'b0;
    if (y_wide < 0) begin
      y_o    = '0;
      clip_o = 1'b1;
    end else if (y_wide > SW'(Y_MAX)) begin
      y_o    = PIX_W'(Y_MAX);
      clip_o = 1'b1;
    end
  end

endmodule

// File: rtl/adc_vscale.sv
// rtl/adc_vscale.sv - two-stage ADC-to-pixel-row scaler with per-channel gain and block averaging
module adc_vscale
  import adc_vscale_pkg::*;
#(
  parameter int  ADC_W     = 14,
  parameter int  PIX_W     = 8,
  parameter int  NCH       = 2,
  parameter int  MAX_SHIFT = PKG_MAX_SHIFT,
  parameter int  DEF_SEL   = PKG_DEF_SEL,
  parameter int  Y_CENTER  = 60,
  parameter int  Y_MAX     = 2**PIX_W - 1,
  parameter int  AVG_LOG   = 2,
  localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ADC_W-1:0] in_data,
  input  logic [CH_W-1:0]  in_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic [CH_W-1:0]  out_ch,
  output logic             out_clip,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [2:0]       cfg_sel,
  input  logic             frame_sync,
  input  logic             avg_en
);

  localparam int                    ACC_W    = ADC_W + 1 + AVG_LOG;
  localparam logic signed [ADC_W:0] MID      = (ADC_W+1)'(2**(ADC_W-1));
  localparam sel_t                  SEL_RST  = sel_t'(DEF_SEL);
  localparam logic [AVG_LOG-1:0]    CNT_LAST = '1;

  sel_t                    sel_pend_q [NCH];
  sel_t                    sel_pend_d [NCH];
  sel_t                    sel_act_q  [NCH];
  sel_t                    sel_act_d  [NCH];
  logic signed [ACC_W-1:0] acc_q      [NCH];
  logic signed [ACC_W-1:0] acc_d      [NCH];
  logic [AVG_LOG-1:0]      cnt_q      [NCH];
  logic [AVG_LOG-1:0]      cnt_d      [NCH];
  logic                    avg_act_q, avg_act_d;

  logic                    s1_valid_q, s1_valid_d;
  logic signed [ADC_W:0]   s1_val_q, s1_val_d;
  logic [CH_W-1:0]         s1_ch_q, s1_ch_d;

  logic                    out_valid_q, out_valid_d;
  logic [PIX_W-1:0]        out_data_q, out_data_d;
  logic [CH_W-1:0]         out_ch_q, out_ch_d;
  logic                    out_clip_q, out_clip_d;

  logic                    s2_advance, accept, in_ch_ok, cfg_ch_ok, blk_done;
  sel_t                    sel_in;
  logic signed [ADC_W:0]   d_raw, d_sh, avg_val;
  logic signed [ACC_W-1:0] acc_sum;
  logic [PIX_W-1:0]        sat_y;
  logic                    sat_clip;

  assign s2_advance = !out_valid_q || out_ready;
  assign in_ready   = rst_n && (!s1_valid_q || s2_advance);
  assign accept     = in_valid && in_ready;
  assign in_ch_ok   = 32'(in_ch) < NCH;
  assign cfg_ch_ok  = 32'(cfg_ch) < NCH;

  assign sel_in   = in_ch_ok ? sel_act_q[in_ch] : SEL_RST;
  assign d_raw    = $signed({1'b0, in_data}) - MID;
  assign d_sh     = d_raw >>> sel_to_shift(sel_in, DEF_SEL, MAX_SHIFT);
  assign acc_sum  = (in_ch_ok ? acc_q[in_ch] : '0) + ACC_W'(d_sh);
  assign avg_val  = (ADC_W+1)'(acc_sum >>> AVG_LOG);
  assign blk_done = in_ch_ok && (cnt_q[in_ch] == CNT_LAST);

  always_comb begin
    sel_pend_d = sel_pend_q;
    sel_act_d  = sel_act_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    avg_act_d  = frame_sync ? avg_en : avg_act_q;

    // A sample landing on frame_sync belongs to the discarded partial block.
    if (frame_sync) begin
      sel_act_d = sel_pend_q;
      for (int i = 0; i < NCH; i++) begin
        acc_d[i] = '0;
        cnt_d[i] = '0;
      end
    end else if (accept && in_ch_ok && avg_act_q) begin
      acc_d[in_ch] = blk_done ? '0 : acc_sum;
      cnt_d[in_ch] = cnt_q[in_ch] + 1'b1;
    end

    if (cfg_we && cfg_ch_ok) begin
      sel_pend_d[cfg_ch] = cfg_sel;
      if (frame_sync) sel_act_d[cfg_ch] = cfg_sel;
    end

    s1_valid_d = s1_valid_q;
    s1_val_d   = s1_val_q;
    s1_ch_d    = s1_ch_q;
    if (in_ready) begin
      s1_valid_d = accept && in_ch_ok && (!avg_act_q || (blk_done && !frame_sync));
      s1_val_d   = avg_act_q ? avg_val : d_sh;
      s1_ch_d    = in_ch;
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_clip_d  = out_clip_q;
    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = sat_y;
        out_ch_d   = s1_ch_q;
        out_clip_d = sat_clip;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        sel_pend_q[i] <= SEL_RST;
        sel_act_q[i]  <= SEL_RST;
        acc_q[i]      <= '0;
        cnt_q[i]      <= '0;
      end
      avg_act_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_val_q    <= '0;
      s1_ch_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_clip_q  <= 1'b0;
    end else begin
      sel_pend_q  <= sel_pend_d;
      sel_act_q   <= sel_act_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      avg_act_q   <= avg_act_d;
      s1_valid_q  <= s1_valid_d;
      s1_val_q    <= s1_val_d;
      s1_ch_q     <= s1_ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_clip_q  <= out_clip_d;
    end
  end

  adc_vscale_sat #(
    .ADC_W   (ADC_W),
    .PIX_W   (PIX_W),
    .Y_CENTER(Y_CENTER),
    .Y_MAX   (Y_MAX)
  ) u_sat (
    .val_i (s1_val_q),
    .y_o   (sat_y),
    .clip_o(sat_clip)
  );

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_clip  = out_clip_q;

endmodule
